// File: rtl/axi_inf_pkg.sv
// Shared types and constants for the AXI write slave core.
// Holds the FSM state encoding and the AXI burst/response codes.
package axi_inf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_inf_addr_gen.sv
// Beat address generator: loads the burst start address and
// advances by the transfer size after every accepted beat.
module axi_inf_addr_gen
    import axi_inf_pkg::*;
#(
    parameter int ASIZE = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [ASIZE-1:0] addr_i,
    input  logic             inc_i,
    input  logic [2:0]       size_i,
    output logic [ASIZE-1:0] addr_o
);

    logic [ASIZE-1:0] addr_q;
    logic [ASIZE-1:0] addr_d;

    // Plain modular add: the address wraps at 2^ASIZE.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = addr_i;
        end else if (inc_i) begin
            addr_d = addr_q + (ASIZE'(1) << size_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/axi_inf_write_slave_core.sv
// AXI write slave: accepts one burst at a time, forwards beats to a
// local sink as registered writes, and returns a single B response.
module axi_inf_write_slave_core
    import axi_inf_pkg::*;
#(
    parameter int IDSIZE = 3,
    parameter int LSIZE  = 10,
    parameter int ASIZE  = 32,
    parameter int DSIZE  = 256
) (
    input  logic                 axi_aclk,
    input  logic                 axi_reset,
    input  logic [IDSIZE-1:0]    axi_awid,
    input  logic [ASIZE-1:0]     axi_awaddr,
    input  logic [LSIZE-1:0]     axi_awlen,
    input  logic [2:0]           axi_awsize,
    input  logic [1:0]           axi_awburst,
    input  logic                 axi_awvalid,
    output logic                 axi_awready,
    input  logic [DSIZE-1:0]     axi_wdata,
    input  logic [DSIZE/8-1:0]   axi_wstrb,
    input  logic                 axi_wlast,
    input  logic                 axi_wvalid,
    output logic                 axi_wready,
    output logic [IDSIZE-1:0]    axi_bid,
    output logic [1:0]           axi_bresp,
    output logic                 axi_bvalid,
    input  logic                 axi_bready,
    output logic                 sink_wr_en,
    output logic [ASIZE-1:0]     sink_addr,
    output logic [DSIZE-1:0]     sink_data,
    output logic [DSIZE/8-1:0]   sink_strb,
    input  logic                 sink_full,
    output logic                 busy,
    output logic                 burst_done,
    output logic [15:0]          err_cnt
);

    localparam int SSIZE = DSIZE / 8;

    state_e             state_q, state_d;
    logic [IDSIZE-1:0]  awid_q, awid_d;
    logic [LSIZE-1:0]   awlen_q, awlen_d;
    logic [2:0]         awsize_q, awsize_d;
    logic [1:0]         awburst_q, awburst_d;
    logic [LSIZE-1:0]   cnt_q, cnt_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               wr_en_q, wr_en_d;
    logic [ASIZE-1:0]   saddr_q, saddr_d;
    logic [DSIZE-1:0]   sdata_q, sdata_d;
    logic [SSIZE-1:0]   sstrb_q, sstrb_d;
    logic               done_q, done_d;
    logic [15:0]        err_q, err_d;

    logic               aw_hs, w_hs, b_hs;
    logic               at_len, beat_last, beat_err;
    logic [ASIZE-1:0]   beat_addr;

    // Handshake readiness is masked during reset so nothing is accepted.
    assign axi_awready = (state_q == ST_IDLE) && !axi_reset;
    assign axi_wready  = (state_q == ST_DATA) && !sink_full && !axi_reset;
    assign axi_bvalid  = (state_q == ST_RESP) && !axi_reset;
    assign busy        = (state_q != ST_IDLE) && !axi_reset;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign b_hs  = axi_bvalid && axi_bready;

    // A burst ends on the length match or on wlast; any mismatch is an error.
    assign at_len    = (cnt_q == awlen_q);
    assign beat_last = at_len || axi_wlast;
    assign beat_err  = (axi_wlast != at_len) || (awburst_q != BURST_INCR);

    axi_inf_addr_gen #(
        .ASIZE (ASIZE)
    ) u_addr_gen (
        .clk_i  (axi_aclk),
        .rst_i  (axi_reset),
        .load_i (aw_hs),
        .addr_i (axi_awaddr),
        .inc_i  (w_hs),
        .size_i (awsize_q),
        .addr_o (beat_addr)
    );

    always_comb begin
        state_d   = state_q;
        awid_d    = awid_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        cnt_d     = cnt_q;
        bresp_d   = bresp_q;
        wr_en_d   = 1'b0;
        saddr_d   = saddr_q;
        sdata_d   = sdata_q;
        sstrb_d   = sstrb_q;
        done_d    = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    awid_d    = axi_awid;
                    awlen_d   = axi_awlen;
                    awsize_d  = axi_awsize;
                    awburst_d = axi_awburst;
                    cnt_d     = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    cnt_d   = cnt_q + LSIZE'(1);
                    wr_en_d = (awburst_q == BURST_INCR);
                    saddr_d = beat_addr;
                    sdata_d = axi_wdata;
                    sstrb_d = axi_wstrb;
                    if (beat_last) begin
                        bresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (bresp_q == RESP_SLVERR && err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q   <= ST_IDLE;
            awid_q    <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            cnt_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wr_en_q   <= 1'b0;
            saddr_q   <= '0;
            sdata_q   <= '0;
            sstrb_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            awid_q    <= awid_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            cnt_q     <= cnt_d;
            bresp_q   <= bresp_d;
            wr_en_q   <= wr_en_d;
            saddr_q   <= saddr_d;
            sdata_q   <= sdata_d;
            sstrb_q   <= sstrb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign axi_bid    = awid_q;
    assign axi_bresp  = bresp_q;
    assign sink_wr_en = wr_en_q;
    assign sink_addr  = saddr_q;
    assign sink_data  = sdata_q;
    assign sink_strb  = sstrb_q;
    assign burst_done = done_q;
    assign err_cnt    = err_q;

endmodule
